// File: rtl/spart_core_if.sv
// spart_core_if: processor-side control/status signals of the SPART (the tri-state databus stays a plain port)
interface spart_core_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;
  modport master (output iocs, iorw, ioaddr, input rda, tbr);
  modport slave (input iocs, iorw, ioaddr, output rda, tbr);
endinterface

// File: rtl/spart_core.sv
// spart_core: bus-side SPART with baud divisor, 8N1 TX and RX; define SPART_FRAMING_ERR_EN for a sticky framing-error status bit
module spart_core #(
  parameter logic [15:0] DEFAULT_DIV = 16'h0145,
  parameter int          OVERSAMPLE  = 16
) (
  input  logic           clk,
  input  logic           rst,
  spart_core_if.slave    bus,
  inout  wire  [7:0]     databus,
  output logic           txd,
  input  logic           rxd
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t tx_st, tx_nx, rx_st, rx_nx;
  logic [15:0] div, cnt, div_wr;
  logic [7:0] tx_sh, rx_sh, rx_buf, status, rd_data;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic [2:0] tx_bit, rx_bit;
  logic tick, wr, rd, tbr, rda, s1, s2, fe;
  logic tx_end, rx_end, rx_half, rx_ok;
  assign wr = bus.iocs && !bus.iorw;
  assign rd = bus.iocs && bus.iorw;
  assign tick = cnt == 16'd0;
  assign div_wr = bus.ioaddr[0] ? {databus, div[7:0]} : {div[15:8], databus};
  assign tx_end = tick && tx_cnt == LAST;
  assign rx_end = tick && rx_cnt == LAST;
  assign rx_half = tick && rx_cnt == HALF;
  assign rx_ok = rx_st == STOP && rx_end && s2;
  assign bus.tbr = tbr;
  assign bus.rda = rda;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      div <= DEFAULT_DIV;
      cnt <= DEFAULT_DIV;
    end else if (wr && bus.ioaddr[1]) begin
      div <= div_wr;
      cnt <= div_wr;
    end else
      cnt <= tick ? div : cnt - 16'd1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tx_st <= IDLE;
      rx_st <= IDLE;
    end else begin
      tx_st <= tx_nx;
      rx_st <= rx_nx;
    end
  always_comb begin
    tx_nx = tx_st;
    case (tx_st)
      IDLE:  if (tick && !tbr) tx_nx = START;
      START: if (tx_end) tx_nx = DATA;
      DATA:  if (tx_end && tx_bit == 3'd7) tx_nx = STOP;
      STOP:  if (tx_end) tx_nx = IDLE;
    endcase
  end
  always_comb begin
    rx_nx = rx_st;
    case (rx_st)
      IDLE:  if (!s2) rx_nx = START;
      START: if (rx_half) rx_nx = s2 ? IDLE : DATA;
      DATA:  if (rx_end && rx_bit == 3'd7) rx_nx = STOP;
      STOP:  if (rx_end) rx_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tbr <= 1'b1;
      txd <= 1'b1;
      tx_sh <= '0;
      tx_cnt <= '0;
      tx_bit <= '0;
    end else begin
      tx_cnt <= tx_st == IDLE ? '0 : tx_cnt + CW'(tick);
      if (wr && bus.ioaddr == 2'b00 && tbr) begin
        tx_sh <= databus;
        tbr <= 1'b0;
      end
      if (tx_st == IDLE && tx_nx == START) txd <= 1'b0;
      if (tx_end && (tx_st == START || tx_st == DATA)) begin
        txd <= tx_st == DATA && tx_bit == 3'd7 ? 1'b1 : tx_sh[0];
        tx_sh <= tx_sh >> 1;
        tx_bit <= tx_st == START ? 3'd0 : tx_bit + 3'd1;
      end
      if (tx_end && tx_st == STOP) tbr <= 1'b1;
    end
  // synchronizer resets to the idle line level so reset release never looks like a start bit
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      rx_sh <= '0;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_buf <= '0;
      rda <= 1'b0;
    end else begin
      s1 <= rxd;
      s2 <= s1;
      rx_cnt <= rx_st == IDLE || (rx_st == START && rx_half) ? '0 : rx_cnt + CW'(tick);
      rx_bit <= rx_st == IDLE ? 3'd0 : rx_bit + 3'(rx_st == DATA && rx_end);
      if (rx_st == DATA && rx_end) rx_sh <= {s2, rx_sh[7:1]};
      if (rx_ok) rx_buf <= rx_sh;
      rda <= rx_ok || (rda && !(rd && bus.ioaddr == 2'b00));
    end
`ifdef SPART_FRAMING_ERR_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) fe <= 1'b0;
    else fe <= (rx_st == STOP && rx_end && !s2) || (fe && !(rd && bus.ioaddr == 2'b01));
`else
  assign fe = 1'b0;
`endif
  assign status = {5'b0, fe, tbr, rda};
  assign rd_data = bus.ioaddr[1] ? (bus.ioaddr[0] ? div[15:8] : div[7:0]) : (bus.ioaddr[0] ? status : rx_buf);
  assign databus = rd ? rd_data : 8'bz;
endmodule

// File: doc/spart_core.md
Name: spart_core

Overview:
- Bus-side SPART (special purpose asynchronous receiver/transmitter) that the processor-side driver programs and exchanges bytes with over an 8-bit tri-state databus.
- Contains a bus register interface, a programmable 16-bit baud divisor generating a 16x oversample tick, an 8N1 transmitter and an 8N1 receiver.
- Serial side connects to txd/rxd of the board UART pins or a loopback in simulation.

Parameters:
- DEFAULT_DIV, 16'h0145, divisor loaded on reset (9600 baud x16 at 50 MHz).
- OVERSAMPLE, 16, ticks per serial bit; must be a power of two, at least 8.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low
- iocs  input  1  chip select, active high
- iorw  input  1  1 = read, 0 = write
- ioaddr  input  2  00 TX/RX buffer, 01 status, 10 divisor low, 11 divisor high
- databus  inout  8  bidirectional data bus
- rda  output  1  receive data available
- tbr  output  1  transmit buffer ready
- txd  output  1  serial transmit, idle high
- rxd  input  1  serial receive, asynchronous to clk

Behaviour:
- Reset values: txd=1, tbr=1, rda=0, rx buffer=0, divisor=DEFAULT_DIV, baud counter=DEFAULT_DIV, all FSMs IDLE. Databus is released (Z).
- Bus write: captured on posedge clk when iocs=1 and iorw=0.
  - 00: load TX shift data; ignored when tbr=0.
  - 01: no effect.
  - 10/11: update the divisor byte and reload the baud counter in the same edge.
- Bus read: databus is driven combinationally only while iocs=1 and iorw=1; otherwise Z.
  - 00 returns the rx buffer. The rising edge of clk with iocs=1, iorw=1 and ioaddr=00 clears rda.
  - 01 returns {6'b0, tbr, rda}.
  - 10/11 return the divisor bytes.
- Baud generator: a 16-bit down counter.
  - At 0, emit a 1-cycle tick and reload the divisor.
  - A divisor of 0 is treated as 1, which gives a tick every cycle.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - An accepted write sets tbr=0 on the next edge and enters START on the next tick.
  - Each bit lasts OVERSAMPLE ticks. Order is start bit 0, d[0]..d[7] LSB first, then stop bit 1.
  - tbr returns to 1 on the tick that completes the stop bit. txd is registered.
- RX input handling: rxd passes through a 2-flop synchronizer.
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - A synchronized low in IDLE enters START. START checks the line at OVERSAMPLE/2 ticks; if it is high, this is a false start and the FSM returns to IDLE.
  - DATA samples 8 bits every OVERSAMPLE ticks, LSB first.
  - STOP samples one more bit. If it is 1, load the rx buffer and set rda=1; if it is 0, discard the byte (framing error).
- Overrun: a new valid byte arriving while rda=1 overwrites the buffer and rda stays 1.
- Simultaneous events: an rx buffer load and a read of 00 on the same edge leave rda=1 and the new data in the buffer.
- Mid-operation changes: a divisor write during a transfer takes effect from the next tick; the frame is not aborted.
- Reset asserted mid-frame returns to the reset values immediately.

Optional Feature:
- SPART_FRAMING_ERR_EN defined:
  - Status bit 2 is a sticky framing-error flag, set when a stop bit samples 0.
  - It is cleared by a status read (iocs=1, iorw=1, ioaddr=01).
  - The status read returns {5'b0, fe, tbr, rda}.
- Undefined: bit 2 reads 0 and framing errors are silently discarded.

Test Plan:
- Reset, then read 01/10/11 -> status 8'h02, divisor 8'h45 and 8'h01; txd=1; databus Z when iocs=0.
- Write div low=8'h04, high=8'h00, then write 00=8'h6D -> tbr=0 the next cycle; txd emits 0,1,0,1,1,0,1,1,0,1, each bit 80 clk (5-cycle tick x16); tbr=1 after the stop bit.
- Write 00 a second time while tbr=0 -> transmitted byte unchanged (6D); no second frame.
- Loop txd to rxd, send 8'hA5 -> rda=1 after the stop bit; read 00 returns 8'hA5; rda=0 after the read edge.
- Drive rxd low for 3 ticks only -> no rda, RX back in IDLE; drive a frame with stop=0 -> rda stays 0; with SPART_FRAMING_ERR_EN, status reads 8'h06 once, then 8'h02.
- Receive 8'h11 then 8'h22 without reading -> rda=1, buffer reads 8'h22; rst pulse mid-TX -> txd=1 and tbr=1 immediately.
